// File: rtl/regfile_wb_sched.sv
// Writeback scheduler that serialises the E and M results of one instruction
// onto a single register-file write port, E first, then M.
module regfile_wb_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        hazard,
    output logic        done,
    output logic [15:0] wr_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR_E = 2'd1;
    localparam logic [1:0] WR_M = 2'd2;
    localparam logic [3:0] NONE = 4'hF;

    logic [1:0]  state_r;
    logic [1:0]  nextState_s;
    logic        accept_s;
    logic        nextDone_s;
    logic [3:0]  capDstE_r;
    logic [3:0]  capDstM_r;
    logic [63:0] capValE_r;
    logic [63:0] capValM_r;
    logic [3:0]  selDstM_s;
    logic [63:0] selValM_s;
    logic [3:0]  nextWaddr_s;
    logic [63:0] nextWdata_s;
    logic        rfWe_r;
    logic [3:0]  rfWaddr_r;
    logic [63:0] rfWdata_r;
    logic        done_r;
    logic [15:0] wrCount_r;
    logic        hazard_s;

    function automatic logic srcHit(input logic [3:0] src, input logic [3:0] dst);
        return (src != NONE) && (src == dst);
    endfunction

    assign wb_ready  = (state_r == IDLE);
    assign accept_s  = wb_valid && wb_ready;
    // The M write can start straight from accept (dstE==F), so pick live inputs then.
    assign selDstM_s = accept_s ? dstM : capDstM_r;
    assign selValM_s = accept_s ? valM : capValM_r;

    // Next-state and retire-pulse decode
    always_comb begin
        nextState_s = state_r;
        nextDone_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    nextState_s = IDLE;
                end else if (dstE != NONE) begin
                    nextState_s = WR_E;
                end else if (dstM != NONE) begin
                    nextState_s = WR_M;
                end else begin
                    nextState_s = IDLE;
                    nextDone_s  = 1'b1;
                end
            end
            WR_E: begin
                if (capDstM_r != NONE) begin
                    nextState_s = WR_M;
                end else begin
                    nextState_s = IDLE;
                    nextDone_s  = 1'b1;
                end
            end
            WR_M: begin
                nextState_s = IDLE;
                nextDone_s  = 1'b1;
            end
            default: begin
                nextState_s = IDLE;
                nextDone_s  = 1'b0;
            end
        endcase
    end

    // Write-port values for the state being entered; WR_E is only entered on accept
    always_comb begin
        nextWaddr_s = NONE;
        nextWdata_s = 64'd0;
        case (nextState_s)
            WR_E: begin
                nextWaddr_s = dstE;
                nextWdata_s = valE;
            end
            WR_M: begin
                nextWaddr_s = selDstM_s;
                nextWdata_s = selValM_s;
            end
            default: begin
                nextWaddr_s = NONE;
                nextWdata_s = 64'd0;
            end
        endcase
    end

    // Hazard against destinations still waiting to be written
    always_comb begin
        hazard_s = 1'b0;
        case (state_r)
            WR_E: hazard_s = srcHit(srcA, capDstE_r) || srcHit(srcB, capDstE_r) ||
                             srcHit(srcA, capDstM_r) || srcHit(srcB, capDstM_r);
            WR_M: hazard_s = srcHit(srcA, capDstM_r) || srcHit(srcB, capDstM_r);
            default: hazard_s = 1'b0;
        endcase
    end

    // FSM state, request capture and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            capDstE_r <= NONE;
            capDstM_r <= NONE;
            capValE_r <= 64'd0;
            capValM_r <= 64'd0;
            rfWe_r    <= 1'b0;
            rfWaddr_r <= NONE;
            rfWdata_r <= 64'd0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            rfWe_r    <= (nextState_s != IDLE);
            rfWaddr_r <= nextWaddr_s;
            rfWdata_r <= nextWdata_s;
            done_r    <= nextDone_s;
            if (accept_s) begin
                capDstE_r <= dstE;
                capDstM_r <= dstM;
                capValE_r <= valE;
                capValM_r <= valM;
            end else begin
                capDstE_r <= capDstE_r;
                capDstM_r <= capDstM_r;
                capValE_r <= capValE_r;
                capValM_r <= capValM_r;
            end
        end
    end

    // Issued-write counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrCount_r <= 16'd0;
        end else if (rfWe_r) begin
            wrCount_r <= wrCount_r + 16'd1;
        end else begin
            wrCount_r <= wrCount_r;
        end
    end

    assign rf_we    = rfWe_r;
    assign rf_waddr = rfWaddr_r;
    assign rf_wdata = rfWdata_r;
    assign done     = done_r;
    assign wr_count = wrCount_r;
    assign hazard   = hazard_s;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomised bench for regfile_wb_sched: each request is expanded into its list
// of pending writes, which drives the expected port activity and hazards.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        hazard;
    logic        done;
    logic [15:0] wr_count;

    int          errCnt = 0;
    int          chkCnt = 0;
    logic [63:0] modelRf [16];
    logic [63:0] seenRf  [16];
    logic [15:0] modelCnt;

    localparam logic [3:0] NONE = 4'hF;
    localparam logic [4:0] RND  = 5'h10;

    regfile_wb_sched dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .hazard(hazard), .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Register file as seen by whatever sits on the write port
    always @(posedge clk) begin
        if (rf_we) seenRf[rf_waddr] <= rf_wdata;
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A source hits if it names any write from index i onward that has not retired
    function automatic logic hzExp(input logic [3:0] src, input logic [3:0] q[$], input int i);
        if (src == NONE) return 1'b0;
        for (int j = i; j < q.size(); j++) if (q[j] == src) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] pickSrc(input logic [4:0] forced, input logic [3:0] q[$]);
        int r;
        if (forced != RND) return forced[3:0];
        r = $urandom_range(0, 3);
        if (r == 0 || q.size() == 0) return NONE;
        if (r == 1) return 4'($urandom_range(0, 14));
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    // Entered and left on a negedge; accepts on the following posedge
    task automatic doRequest(input logic [3:0] dE, input logic [63:0] vE,
                             input logic [3:0] dM, input logic [63:0] vM,
                             input logic [4:0] sA0, input logic [4:0] sB0,
                             input logic [4:0] sA1, input logic [4:0] sB1);
        logic [3:0]  wA[$];
        logic [63:0] wD[$];
        logic [3:0]  s;
        if (dE != NONE) begin wA.push_back(dE); wD.push_back(vE); end
        if (dM != NONE) begin wA.push_back(dM); wD.push_back(vM); end
        checkEq("ready_before", wb_ready, 1'b1);
        wb_valid = 1'b1; dstE = dE; dstM = dM; valE = vE; valM = vM;
        @(negedge clk);
        for (int i = 0; i < wA.size(); i++) begin
            wb_valid = 1'($urandom_range(0, 1));
            dstE = 4'($urandom); dstM = 4'($urandom);
            valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
            srcA = NONE; srcB = NONE;
            #1;
            checkEq("we", rf_we, 1'b1);
            checkEq("waddr", rf_waddr, wA[i]);
            checkEq("wdata", rf_wdata, wD[i]);
            checkEq("done_busy", done, 1'b0);
            checkEq("ready_busy", wb_ready, 1'b0);
            checkEq("hazard_none", hazard, 1'b0);
            s = pickSrc(i == 0 ? sA0 : sA1, wA);
            srcA = s; #1;
            checkEq("hazard_a", hazard, hzExp(s, wA, i));
            srcA = NONE;
            s = pickSrc(i == 0 ? sB0 : sB1, wA);
            srcB = s; #1;
            checkEq("hazard_b", hazard, hzExp(s, wA, i));
            modelRf[wA[i]] = wD[i];
            modelCnt++;
            @(negedge clk);
        end
        wb_valid = 1'b0;
        srcA = 4'($urandom_range(0, 14)); srcB = 4'($urandom_range(0, 14));
        #1;
        checkEq("done", done, 1'b1);
        checkEq("we_idle", rf_we, 1'b0);
        checkEq("waddr_idle", rf_waddr, NONE);
        checkEq("wdata_idle", rf_wdata, 64'd0);
        checkEq("ready_idle", wb_ready, 1'b1);
        checkEq("hazard_idle", hazard, 1'b0);
        checkEq("wr_count", wr_count, modelCnt);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            checkEq("done_quiet", done, 1'b0);
            checkEq("we_quiet", rf_we, 1'b0);
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin modelRf[r] = 64'd0; seenRf[r] = 64'd0; end
        modelCnt = 16'd0;
        rst_n = 1'b0; wb_valid = 1'b0; dstE = 4'd3; dstM = 4'd3;
        valE = 64'd0; valM = 64'd0; srcA = 4'd3; srcB = 4'd3;
        @(negedge clk); @(negedge clk); #1;
        checkEq("rst_ready", wb_ready, 1'b1);
        checkEq("rst_we", rf_we, 1'b0);
        checkEq("rst_waddr", rf_waddr, NONE);
        checkEq("rst_wdata", rf_wdata, 64'd0);
        checkEq("rst_done", done, 1'b0);
        checkEq("rst_hazard", hazard, 1'b0);
        checkEq("rst_count", wr_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        doRequest(4'd3, 64'd525, NONE, 64'd0, RND, RND, RND, RND);
        doRequest(4'd4, 64'h108, 4'd0, 64'd300, 5'd0, RND, 5'd4, 5'd0);
        doRequest(4'd4, 64'd251, 4'd4, 64'd999, 5'd4, RND, 5'd4, RND);
        checkEq("r4_same_reg", seenRf[4], 64'd999);
        doRequest(NONE, 64'd7, NONE, 64'd9, RND, RND, RND, RND);
        idleCycles(2);
        doRequest(NONE, 64'd1, 4'd6, 64'd66, RND, RND, 5'd6, RND);

        // Reset while in WR_E of a two-write request
        @(negedge clk);
        wb_valid = 1'b1; dstE = 4'd4; valE = 64'h108; dstM = 4'd0; valM = 64'd300;
        @(negedge clk);
        wb_valid = 1'b0; srcA = 4'd0; #1;
        checkEq("mid_we", rf_we, 1'b1);
        rst_n = 1'b0; #1;
        modelCnt = 16'd0;
        checkEq("mid_rst_we", rf_we, 1'b0);
        checkEq("mid_rst_count", wr_count, 16'd0);
        checkEq("mid_rst_ready", wb_ready, 1'b1);
        checkEq("mid_rst_hazard", hazard, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(4);
        checkEq("mid_rst_count_after", wr_count, 16'd0);

        for (int n = 0; n < 60; n++) begin
            logic [3:0] e, m;
            e = ($urandom_range(0, 3) == 0) ? NONE : 4'($urandom_range(0, 14));
            m = ($urandom_range(0, 3) == 0) ? NONE : 4'($urandom_range(0, 14));
            doRequest(e, {$urandom, $urandom}, m, {$urandom, $urandom}, RND, RND, RND, RND);
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
        end

        @(negedge clk);
        for (int r = 0; r < 15; r++) checkEq($sformatf("rf_r%0d", r), seenRf[r], modelRf[r]);
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: wb_valid  input  1  writeback request present.
REQ-004 SHALL have port: wb_ready  output  1  scheduler can accept a request.
REQ-005 SHALL have port: dstE  input  4  E-port destination register; 4'hF = none.
REQ-006 SHALL have port: dstM  input  4  M-port destination register; 4'hF = none.
REQ-007 SHALL have port: valE  input  64  data for dstE.
REQ-008 SHALL have port: valM  input  64  data for dstM.
REQ-009 SHALL have port: srcA  input  4  decode-stage read address A; 4'hF = none.
REQ-010 SHALL have port: srcB  input  4  decode-stage read address B; 4'hF = none.
REQ-011 SHALL have port: rf_we  output  1  register-file write enable (single write port).
REQ-012 SHALL have port: rf_waddr  output  4  register-file write address.
REQ-013 SHALL have port: rf_wdata  output  64  register-file write data.
REQ-014 SHALL have port: hazard  output  1  srcA/srcB matches a not-yet-written pending destination.
REQ-015 SHALL have port: done  output  1  one-cycle pulse when an accepted request has fully retired.
REQ-016 SHALL have port: wr_count  output  16  count of issued register writes.

Function
REQ-017 SHALL implement FSM states IDLE, WR_E, WR_M; wb_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where wb_valid=1 and wb_ready=1, capturing dstE, dstM, valE, valM into internal registers.
REQ-019 On accept, SHALL go to WR_E if dstE!=F, else WR_M if dstM!=F, else stay IDLE (no-write request).
REQ-020 In WR_E SHALL drive rf_we=1, rf_waddr=captured dstE, rf_wdata=captured valE; next state WR_M if captured dstM!=F, else IDLE.
REQ-021 In WR_M SHALL drive rf_we=1, rf_waddr=captured dstM, rf_wdata=captured valM; next state IDLE.
REQ-022 In IDLE SHALL drive rf_we=0; rf_waddr=4'hF and rf_wdata=0 whenever rf_we=0.
REQ-023 E write SHALL always precede M write, so that when dstE==dstM the register ends holding valM.
REQ-024 SHALL assert done (registered) for exactly one cycle: the cycle after the final write state, or the cycle after accept for a no-write request.
REQ-025 Latency: first write cycle begins one cycle after accept; a two-write request occupies 2 cycles, and the next accept is possible on the edge ending the final write state's successor IDLE cycle.
REQ-026 hazard (combinational) SHALL be 1 when a non-F srcA or srcB equals captured dstE while in WR_E, or equals captured dstM while in WR_E or WR_M; 0 in IDLE.
REQ-027 wr_count SHALL increment by 1 on every rising edge with rf_we=1, wrapping 16'hFFFF -> 16'h0000.
REQ-028 wb_valid while not ready SHALL be ignored; inputs need not be held after accept.
REQ-029 Expected RTL size: 120-400 lines.

Reset
REQ-030 On rst_n=0, SHALL immediately (asynchronously) enter IDLE, with rf_we=0, rf_waddr=4'hF, rf_wdata=0, done=0, hazard=0, wr_count=0, wb_ready=1, and all captured registers cleared to dst=F, val=0.
REQ-031 Reset during WR_E/WR_M SHALL discard the pending request; no further write and no done pulse for it after release.
REQ-032 First accept possible on the first rising edge with rst_n=1.

Verification
REQ-033 irmovq-style: dstE=3, valE=525, dstM=F -> one cycle rf_we=1, waddr=3, wdata=525; done next cycle; wr_count=1.
REQ-034 popq-style: dstE=4, valE=0x108, dstM=0, valM=300 -> waddr=4/wdata=0x108, then waddr=0/wdata=300 on consecutive cycles; done after; wr_count +2.
REQ-035 Same register: dstE=4, valE=251, dstM=4, valM=999 -> two writes to r4, last wdata=999; register file reads 999 afterward.
REQ-036 No-write: dstE=F, dstM=F -> rf_we never asserted, done pulses one cycle after accept, wr_count unchanged.
REQ-037 Hazard: during WR_E of REQ-034, srcA=0 -> hazard=1; during WR_M, srcA=4 -> hazard=0 and srcB=0 -> hazard=1; srcA=F -> hazard=0.
REQ-038 Reset mid-op: assert rst_n=0 in WR_E of REQ-034 -> rf_we drops immediately, wr_count=0, wb_ready=1, no done pulse and no write to r0 after release.
